multiword_add_seq: RTL
======================

# multiword_add_seq

Multi-precision add sequencer that shares a single `prefix_adder_16` instance to add two `WORDS`×16-bit operands, one 16-bit slice per cycle, least-significant slice first. The carry is registered between slices. The block sits between a requester (start/done handshake) and the 16-bit prefix-adder datapath. It provides wide addition without replicating the adder.

## Interface
- `WORDS`, default 4: number of 16-bit slices; legal range 2..16; operand width is `WORDS*16`.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `a`  in  `WORDS*16`  operand A; sampled on an accepted start.
- `b`  in  `WORDS*16`  operand B; sampled on an accepted start.
- `cin`  in  1  carry-in; sampled on an accepted start.
- `sub`  in  1  subtract select; port exists only with `MULTIWORD_ADD_SEQ_SUB_EN`.
- `busy`  out  1  operation in progress; start is ignored while this is high.
- `done`  out  1  one-cycle pulse; `s`, `cout` and `ovf` are valid from this cycle.
- `s`  out  `WORDS*16`  sum.
- `cout`  out  1  carry out of the most-significant bit.
- `ovf`  out  1  two's-complement overflow of the full-width result.

## Operation
- **Single datapath:** exactly one `prefix_adder_16` instance. Its ports are `a`, `b`, `cin`, `s`, `cout`. No other adder may be used for the slice sum.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE, start=1: latch `a`, `b` and `cin` into operand registers, set slice index=0, set carry register=`cin`, go to RUN.
  - RUN:
    - Feed the adder slice[idx] of the latched A and B, plus the carry register.
    - Write the adder sum into work-result slice[idx].
    - Load the carry register with the adder `cout`.
    - If idx=`WORDS`-1, go to DONE; otherwise idx+1.
  - DONE:
    - Copy the work result to `s`.
    - Load `cout` from the carry register.
    - Compute `ovf` = carry into MSB XOR carry out of MSB. The carry into the MSB is `A[msb]^B'[msb]^s[msb]`, where B' is the B value actually added.
    - Pulse `done`.
    - start=1 in this state: accept a new operation and go to RUN (back-to-back). start=0: go to IDLE.
- `busy`=1 in RUN only.
- `s`, `cout` and `ovf` change only on the cycle `done` is asserted. They hold their value until the next `done` or reset.
- Inputs `a`, `b` and `cin` may change freely after acceptance. Only the latched copies are used.
- **Width rules:**
  - Slice k is bits [16k+15:16k].
  - The result is exact modulo 2^(`WORDS*16`).
  - `{cout, s}` equals `a+b+cin` evaluated at `WORDS*16`+1 bits.

## Timing
- Reset (asynchronous, immediate on `reset_n`=0): state=IDLE, idx=0, all registers 0, `busy`=0, `done`=0, `s`=0, `cout`=0, `ovf`=0.
- Reset mid-RUN abandons the operation. No `done` is produced.
- Latency: start accepted at edge T means `busy` is high during cycles T+1..T+`WORDS`, and `done` is high for the single cycle after edge T+`WORDS`+1.
- Throughput: one operation per `WORDS`+1 cycles with back-to-back starts.
- start held high through RUN is ignored. It is accepted again at DONE.
- The carry register is the only inter-slice path. The adder sees exactly one slice per cycle.

## Configuration
- `MULTIWORD_ADD_SEQ_SUB_EN` defined:
  - The `sub` port exists.
  - On an accepted start with `sub`=1, B is latched bitwise-inverted, the initial carry is forced to 1 and `cin` is ignored.
  - The result is A−B.
  - `cout`=1 means no borrow.
  - `ovf` is the signed subtraction overflow.
  - With `sub`=0, behaviour is identical to the undefined case.
- Undefined: no `sub` port; add only.

## Test plan
- **Basic add:** `WORDS`=4, a=980, b=722, cin=0, start one cycle → `done` exactly 5 cycles after the accepting edge; s=1702, cout=0, ovf=0; `busy` high 4 cycles.
- **Full carry ripple:** a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → s=0, cout=1, ovf=0. Check the carry crosses all 3 slice boundaries.
- **Signed overflow:** a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → s=0x8000_0000_0000_0000, cout=0, ovf=1.
- **Start handling:**
  - First op a=65535, b=5412, cin=1.
  - During RUN, present start=1 with a=678, b=999 → ignored; first result s=70948, cout=0.
  - Start at the DONE cycle with a=678, b=999, cin=1 → accepted; next `done` 5 cycles later with s=1678.
- **Reset mid-op:** assert `reset_n`=0 two cycles into RUN → `busy`, `done`, `s`, `cout` and `ovf` are all 0 immediately and no `done` occurs. After release, a=444, b=7 → s=451.
- **Subtract (`MULTIWORD_ADD_SEQ_SUB_EN`):** sub=1, a=560, b=677 → s=0xFFFF_FFFF_FFFF_FF8B, cout=0, ovf=0. Then sub=1, a=677, b=560 → s=117, cout=1.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Multi-precision add sequencer: one 16-bit prefix adder, one slice per cycle.
// Optional subtract mode via MULTIWORD_ADD_SEQ_SUB_EN (adds the sub port).
module prefix_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] gl [5];
  logic [15:0] pl [5];
  logic [16:0] c;

  // Kogge-Stone group generate/propagate over spans 1,2,4,8
  always_comb begin
    gl[0] = a & b;
    pl[0] = a ^ b;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << l)) begin
          gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
          pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
        end else begin
          gl[l+1][i] = gl[l][i];
          pl[l+1][i] = pl[l][i];
        end
      end
    end
    c[0] = cin;
    for (int i = 0; i < 16; i++)
      c[i+1] = gl[4][i] | (pl[4][i] & cin);
  end

  assign s    = pl[0] ^ c[15:0];
  assign cout = c[16];
endmodule

module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WORDS*16-1:0] a,
  input  logic [WORDS*16-1:0] b,
  input  logic               cin,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               busy,
  output logic               done,
  output logic [WORDS*16-1:0] s,
  output logic               cout,
  output logic               ovf
);
  localparam int W  = WORDS * 16;
  localparam int IW = $clog2(WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DN   = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  work;
  logic          carry;

  logic [15:0]   sa;
  logic [15:0]   sb;
  logic [15:0]   ss;
  logic          sc;
  logic          accept;
  logic          last;
  logic [W-1:0]  bsel;
  logic          csel;
  logic          cmsb;

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  assign bsel = sub ? ~b : b;
  assign csel = sub ? 1'b1 : cin;
`else
  assign bsel = b;
  assign csel = cin;
`endif

  assign accept = start && (state == IDLE || state == DN);
  assign last   = (idx == IW'(WORDS - 1));
  assign sa     = opa[{idx, 4'b0000} +: 16];
  assign sb     = opb[{idx, 4'b0000} +: 16];
  assign busy   = (state == RUN);
  // carry into the MSB recovered from the stored operands and sum bit
  assign cmsb   = opa[W-1] ^ opb[W-1] ^ work[W-1];

  prefix_adder_16 u_add (
    .a    (sa),
    .b    (sb),
    .cin  (carry),
    .s    (ss),
    .cout (sc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        RUN: begin
          work[{idx, 4'b0000} +: 16] <= ss;
          carry <= sc;
          if (last) begin
            state <= DN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DN: begin
          s     <= work;
          cout  <= carry;
          ovf   <= cmsb ^ carry;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        opa   <= a;
        opb   <= bsel;
        carry <= csel;
        idx   <= '0;
        state <= RUN;
      end
    end
  end
endmodule
